// File: rtl/fcb_baud_arbiter.sv
// Round-robin sequencer that shares one baud generator between two serial requesters.
// Define FCB_BAUD_ARB_WDOG_EN to add the missing-strobe watchdog and the ERR state.
module fcb_baud_arbiter #(
    parameter int NUM_BITS_W = 8
) (
    input  logic                  Bus_Clk_i,
    input  logic                  RST_i,
    input  logic [1:0]            Req_i,
    input  logic [15:0]           Req0_Divisor_i,
    input  logic [15:0]           Req1_Divisor_i,
    input  logic [NUM_BITS_W-1:0] Req0_Bits_i,
    input  logic [NUM_BITS_W-1:0] Req1_Bits_i,
    input  logic                  Baud_rate_fe_i,
    output logic [15:0]           Divisor_o,
    output logic                  Clear_Br_Cnt_o,
    output logic [1:0]            Gnt_o,
    output logic [1:0]            Done_o,
    output logic [1:0]            Err_o,
    output logic                  Busy_o,
    output logic                  Bit_Tick_o,
    output logic [NUM_BITS_W-1:0] Bit_Cnt_o
);
    localparam logic [NUM_BITS_W-1:0] CNT_ONE = NUM_BITS_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
`ifdef FCB_BAUD_ARB_WDOG_EN
        , ST_ERR
`endif
    } state_t;

    state_t                state_q, state_d;
    logic                  gnt_idx_q;  // requester owning the current grant
    logic                  last_q;     // requester granted most recently
    logic [NUM_BITS_W-1:0] bits_q;
    logic                  win;
    logic [15:0]           win_div;
    logic [NUM_BITS_W-1:0] win_bits;
    logic                  req_held;
    logic                  fe_last;

    function automatic logic [1:0] one_hot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    // Req1 wins alone, or on a tie when req0 held the previous grant.
    assign win      = Req_i[1] & (~Req_i[0] | ~last_q);
    assign win_div  = win ? Req1_Divisor_i : Req0_Divisor_i;
    assign win_bits = win ? Req1_Bits_i : Req0_Bits_i;
    assign req_held = Req_i[gnt_idx_q];
    assign fe_last  = Baud_rate_fe_i && (Bit_Cnt_o == bits_q - CNT_ONE);

    assign Bit_Tick_o = Baud_rate_fe_i && (state_q == ST_RUN);

`ifdef FCB_BAUD_ARB_WDOG_EN
    logic [17:0] wdog_q;
    logic [17:0] wdog_limit;
    logic        wdog_hit;

    assign wdog_limit = {1'b0, Divisor_o, 1'b0} + 18'd4;
    assign wdog_hit   = (wdog_q == wdog_limit);

    // Held at zero outside RUN, which also gives the clear on RUN entry.
    always_ff @(posedge Bus_Clk_i or posedge RST_i) begin
        if (RST_i) begin
            wdog_q <= '0;
            Err_o  <= 2'b00;
        end else begin
            wdog_q <= (state_q != ST_RUN || Baud_rate_fe_i) ? 18'd0 : wdog_q + 18'd1;
            Err_o  <= (state_d == ST_ERR) ? one_hot(gnt_idx_q) : 2'b00;
        end
    end
`else
    assign Err_o = 2'b00;
`endif

    // NOTE: next state gets its default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (Req_i != 2'b00) state_d = ST_LOAD;
            ST_LOAD: begin
                if (!req_held)            state_d = ST_IDLE;
                else if (bits_q == '0)    state_d = ST_DONE;
                else                      state_d = ST_RUN;
            end
            ST_RUN: begin
                if (fe_last)              state_d = ST_DONE;
                else if (!req_held)       state_d = ST_IDLE;
`ifdef FCB_BAUD_ARB_WDOG_EN
                else if (wdog_hit && !Baud_rate_fe_i) state_d = ST_ERR;
`endif
            end
            default:                      state_d = ST_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge Bus_Clk_i or posedge RST_i) begin
        if (RST_i) begin
            state_q        <= ST_IDLE;
            gnt_idx_q      <= 1'b0;
            last_q         <= 1'b1;
            bits_q         <= '0;
            Divisor_o      <= 16'h0001;
            Clear_Br_Cnt_o <= 1'b1;
            Gnt_o          <= 2'b00;
            Done_o         <= 2'b00;
            Busy_o         <= 1'b0;
            Bit_Cnt_o      <= '0;
        end else begin
            state_q        <= state_d;
            Clear_Br_Cnt_o <= (state_d != ST_RUN);
            Busy_o         <= (state_d != ST_IDLE);
            Done_o         <= (state_d == ST_DONE) ? one_hot(gnt_idx_q) : 2'b00;
            if (state_d == ST_LOAD) begin
                gnt_idx_q <= win;
                last_q    <= win;
                Divisor_o <= (win_div == 16'd0) ? 16'd1 : win_div;
                bits_q    <= win_bits;
                Bit_Cnt_o <= '0;
                Gnt_o     <= one_hot(win);
            end else begin
                Gnt_o <= (state_d == ST_IDLE) ? 2'b00 : one_hot(gnt_idx_q);
                if (state_q == ST_RUN && Baud_rate_fe_i) Bit_Cnt_o <= Bit_Cnt_o + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_fcb_baud_arbiter.sv
// Self-checking bench for fcb_baud_arbiter: directed scenarios plus randomized grants
// checked against a cycle-count model of the arbitration and timing rules.
module tb_fcb_baud_arbiter;
    localparam int NBW  = 8;
    localparam int MAXC = 96;

    logic           Bus_Clk_i      = 1'b0;
    logic           RST_i          = 1'b1;
    logic [1:0]     Req_i          = 2'b00;
    logic [15:0]    Req0_Divisor_i = 16'd1;
    logic [15:0]    Req1_Divisor_i = 16'd1;
    logic [NBW-1:0] Req0_Bits_i    = '0;
    logic [NBW-1:0] Req1_Bits_i    = '0;
    logic           Baud_rate_fe_i = 1'b0;
    logic [15:0]    Divisor_o;
    logic           Clear_Br_Cnt_o;
    logic [1:0]     Gnt_o;
    logic [1:0]     Done_o;
    logic [1:0]     Err_o;
    logic           Busy_o;
    logic           Bit_Tick_o;
    logic [NBW-1:0] Bit_Cnt_o;

    fcb_baud_arbiter #(.NUM_BITS_W(NBW)) dut (
        .Bus_Clk_i      (Bus_Clk_i),
        .RST_i          (RST_i),
        .Req_i          (Req_i),
        .Req0_Divisor_i (Req0_Divisor_i),
        .Req1_Divisor_i (Req1_Divisor_i),
        .Req0_Bits_i    (Req0_Bits_i),
        .Req1_Bits_i    (Req1_Bits_i),
        .Baud_rate_fe_i (Baud_rate_fe_i),
        .Divisor_o      (Divisor_o),
        .Clear_Br_Cnt_o (Clear_Br_Cnt_o),
        .Gnt_o          (Gnt_o),
        .Done_o         (Done_o),
        .Err_o          (Err_o),
        .Busy_o         (Busy_o),
        .Bit_Tick_o     (Bit_Tick_o),
        .Bit_Cnt_o      (Bit_Cnt_o)
    );

    always #5 Bus_Clk_i = ~Bus_Clk_i;

    int total    = 0;
    int bad      = 0;
    int last_gnt = 1;

    // Baud generator stand-in: a strobe every 2*D cycles once the clear is released.
    logic        fe_en   = 1'b1;
    int unsigned low_cnt = 0;
    always @(posedge Bus_Clk_i) begin
        #1;
        if (Clear_Br_Cnt_o) begin
            low_cnt        = 0;
            Baud_rate_fe_i = 1'b0;
        end else begin
            Baud_rate_fe_i = fe_en && low_cnt != 0 && (low_cnt % (2 * int'(Divisor_o))) == 0;
            low_cnt++;
        end
    end

    logic [1:0]     tr_gnt  [0:MAXC];
    logic [1:0]     tr_done [0:MAXC];
    logic [1:0]     tr_err  [0:MAXC];
    logic           tr_clr  [0:MAXC];
    logic           tr_busy [0:MAXC];
    logic           tr_tick [0:MAXC];
    logic [15:0]    tr_div  [0:MAXC];
    logic [NBW-1:0] tr_cnt  [0:MAXC];

    task automatic sample(input int c);
        tr_gnt[c]  = Gnt_o;
        tr_done[c] = Done_o;
        tr_err[c]  = Err_o;
        tr_clr[c]  = Clear_Br_Cnt_o;
        tr_busy[c] = Busy_o;
        tr_tick[c] = Bit_Tick_o;
        tr_div[c]  = Divisor_o;
        tr_cnt[c]  = Bit_Cnt_o;
    endtask

    // Called at a negedge of cycle 0; records cycles 0..ncyc. Requesters drop after Done/Err.
    task automatic run_cycles(input logic [1:0] req, input int ncyc, input int drop_at,
                              input logic [1:0] drop_mask, input logic scramble);
        sample(0);
        Req_i = req;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge Bus_Clk_i);
            sample(c);
            Req_i = Req_i & ~(Done_o | Err_o);
            if (c == drop_at) Req_i = Req_i & ~drop_mask;
            if (scramble) begin
                Req0_Divisor_i = 16'($urandom);
                Req1_Divisor_i = 16'($urandom);
                Req0_Bits_i    = NBW'($urandom);
                Req1_Bits_i    = NBW'($urandom);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge Bus_Clk_i);
        RST_i = 1'b1;
        Req_i = 2'b00;
        repeat (2) @(negedge Bus_Clk_i);
        RST_i    = 1'b0;
        last_gnt = 1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (Divisor_o !== 16'h0001) begin bad++; $display("FAIL reset divisor got=%h exp=0001", Divisor_o); end
        total++; if (Clear_Br_Cnt_o !== 1'b1) begin bad++; $display("FAIL reset clear got=%b exp=1", Clear_Br_Cnt_o); end
        total++; if (Gnt_o !== 2'b00) begin bad++; $display("FAIL reset gnt got=%b exp=00", Gnt_o); end
        total++; if (Done_o !== 2'b00 || Err_o !== 2'b00) begin bad++; $display("FAIL reset done/err got=%b/%b exp=00/00", Done_o, Err_o); end
        total++; if (Busy_o !== 1'b0 || Bit_Tick_o !== 1'b0) begin bad++; $display("FAIL reset busy/tick got=%b/%b exp=0/0", Busy_o, Bit_Tick_o); end
        total++; if (Bit_Cnt_o !== '0) begin bad++; $display("FAIL reset bitcnt got=%0d exp=0", Bit_Cnt_o); end
    endtask

    task automatic test_single();
        logic exp_b;
        Req0_Divisor_i = 16'd3;
        Req0_Bits_i    = 8'd2;
        run_cycles(2'b01, 17, -1, 2'b00, 1'b0);
        total++; if (tr_gnt[1] !== 2'b01) begin bad++; $display("FAIL single gnt got=%b exp=01", tr_gnt[1]); end
        total++; if (tr_div[1] !== 16'd3) begin bad++; $display("FAIL single divisor got=%0d exp=3", tr_div[1]); end
        for (int c = 0; c <= 17; c++) begin
            exp_b = !(c >= 2 && c <= 14);
            total++; if (tr_clr[c] !== exp_b) begin bad++; $display("FAIL single clear c=%0d got=%b exp=%b", c, tr_clr[c], exp_b); end
            exp_b = (c == 8 || c == 14);
            total++; if (tr_tick[c] !== exp_b) begin bad++; $display("FAIL single tick c=%0d got=%b exp=%b", c, tr_tick[c], exp_b); end
            total++; if (tr_done[c] !== ((c == 15) ? 2'b01 : 2'b00)) begin bad++; $display("FAIL single done c=%0d got=%b", c, tr_done[c]); end
        end
        total++; if (tr_cnt[15] !== 8'd2) begin bad++; $display("FAIL single bitcnt got=%0d exp=2", tr_cnt[15]); end
        total++; if (tr_gnt[15] !== 2'b01 || tr_gnt[16] !== 2'b00) begin bad++; $display("FAIL single gnt hold got=%b,%b exp=01,00", tr_gnt[15], tr_gnt[16]); end
        total++; if (tr_busy[16] !== 1'b0) begin bad++; $display("FAIL single busy after got=%b exp=0", tr_busy[16]); end
    endtask

    task automatic test_tie();
        do_reset();
        Req0_Divisor_i = 16'd1; Req0_Bits_i = 8'd1;
        Req1_Divisor_i = 16'd2; Req1_Bits_i = 8'd1;
        run_cycles(2'b11, 6, -1, 2'b00, 1'b0);
        total++; if (tr_gnt[1] !== 2'b01) begin bad++; $display("FAIL tie first gnt got=%b exp=01", tr_gnt[1]); end
        total++; if (tr_done[5] !== 2'b01 || tr_done[4] !== 2'b00) begin bad++; $display("FAIL tie first done got c4=%b c5=%b exp 00,01", tr_done[4], tr_done[5]); end
        total++; if (tr_gnt[6] !== 2'b00) begin bad++; $display("FAIL tie idle gap gnt got=%b exp=00", tr_gnt[6]); end
        run_cycles(2'b10, 8, -1, 2'b00, 1'b0);
        total++; if (tr_gnt[1] !== 2'b10) begin bad++; $display("FAIL tie second gnt got=%b exp=10", tr_gnt[1]); end
        total++; if (tr_div[1] !== 16'd2) begin bad++; $display("FAIL tie second divisor got=%0d exp=2", tr_div[1]); end
        total++; if (tr_done[7] !== 2'b10) begin bad++; $display("FAIL tie second done got=%b exp=10", tr_done[7]); end
        run_cycles(2'b11, 6, -1, 2'b00, 1'b0);
        Req_i = 2'b00;
        total++; if (tr_gnt[1] !== 2'b01) begin bad++; $display("FAIL tie third gnt got=%b exp=01", tr_gnt[1]); end
        total++; if (tr_done[5] !== 2'b01) begin bad++; $display("FAIL tie third done got=%b exp=01", tr_done[5]); end
    endtask

    task automatic test_zero();
        Req1_Divisor_i = 16'd0;
        Req1_Bits_i    = 8'd0;
        run_cycles(2'b10, 4, -1, 2'b00, 1'b0);
        total++; if (tr_div[1] !== 16'd1) begin bad++; $display("FAIL zero divisor got=%0d exp=1", tr_div[1]); end
        total++; if (tr_gnt[1] !== 2'b10) begin bad++; $display("FAIL zero gnt got=%b exp=10", tr_gnt[1]); end
        for (int c = 0; c <= 4; c++) begin
            total++; if (tr_done[c] !== ((c == 2) ? 2'b10 : 2'b00)) begin bad++; $display("FAIL zero done c=%0d got=%b", c, tr_done[c]); end
            total++; if (tr_clr[c] !== 1'b1) begin bad++; $display("FAIL zero clear c=%0d got=%b exp=1", c, tr_clr[c]); end
        end
        total++; if (tr_busy[3] !== 1'b0) begin bad++; $display("FAIL zero busy after got=%b exp=0", tr_busy[3]); end
    endtask

    task automatic test_abort();
        Req0_Divisor_i = 16'd4;
        Req0_Bits_i    = 8'd3;
        run_cycles(2'b01, 9, 5, 2'b01, 1'b0);
        total++; if (tr_gnt[5] !== 2'b01 || tr_clr[5] !== 1'b0) begin bad++; $display("FAIL abort run gnt/clear got=%b/%b exp=01/0", tr_gnt[5], tr_clr[5]); end
        total++; if (tr_gnt[6] !== 2'b00 || tr_clr[6] !== 1'b1 || tr_busy[6] !== 1'b0) begin bad++; $display("FAIL abort idle gnt/clear/busy got=%b/%b/%b exp=00/1/0", tr_gnt[6], tr_clr[6], tr_busy[6]); end
        for (int c = 0; c <= 9; c++) begin
            total++; if (tr_done[c] !== 2'b00) begin bad++; $display("FAIL abort done c=%0d got=%b exp=00", c, tr_done[c]); end
        end
        run_cycles(2'b01, 4, 1, 2'b01, 1'b0);
        total++; if (tr_gnt[1] !== 2'b01 || tr_gnt[2] !== 2'b00) begin bad++; $display("FAIL abort load gnt got=%b,%b exp=01,00", tr_gnt[1], tr_gnt[2]); end
        total++; if (tr_busy[2] !== 1'b0 || tr_clr[2] !== 1'b1) begin bad++; $display("FAIL abort load busy/clear got=%b/%b exp=0/1", tr_busy[2], tr_clr[2]); end
        total++; if ((tr_done[2] | tr_done[3]) !== 2'b00) begin bad++; $display("FAIL abort load done got=%b exp=00", tr_done[2] | tr_done[3]); end
    endtask

    task automatic test_abort_final();
        Req0_Divisor_i = 16'd1;
        Req0_Bits_i    = 8'd2;
        run_cycles(2'b01, 9, 6, 2'b01, 1'b0);
        total++; if (tr_tick[6] !== 1'b1) begin bad++; $display("FAIL final-fe tick got=%b exp=1", tr_tick[6]); end
        total++; if (tr_done[7] !== 2'b01) begin bad++; $display("FAIL final-fe done got=%b exp=01", tr_done[7]); end
        total++; if (tr_cnt[7] !== 8'd2) begin bad++; $display("FAIL final-fe bitcnt got=%0d exp=2", tr_cnt[7]); end
    endtask

    task automatic test_watchdog();
        fe_en          = 1'b0;
        Req0_Divisor_i = 16'd2;
        Req0_Bits_i    = 8'd1;
        run_cycles(2'b01, 16, 16, 2'b01, 1'b0);
        @(negedge Bus_Clk_i);
        fe_en = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            total++; if (tr_done[c] !== 2'b00) begin bad++; $display("FAIL wdog done c=%0d got=%b exp=00", c, tr_done[c]); end
`ifdef FCB_BAUD_ARB_WDOG_EN
            total++; if (tr_err[c] !== ((c == 11) ? 2'b01 : 2'b00)) begin bad++; $display("FAIL wdog err c=%0d got=%b", c, tr_err[c]); end
`else
            total++; if (tr_err[c] !== 2'b00) begin bad++; $display("FAIL wdog err c=%0d got=%b exp=00", c, tr_err[c]); end
            if (c >= 2) begin
                total++; if (tr_busy[c] !== 1'b1 || tr_clr[c] !== 1'b0) begin bad++; $display("FAIL wdog stuck-run c=%0d busy/clear got=%b/%b exp=1/0", c, tr_busy[c], tr_clr[c]); end
            end
`endif
        end
`ifdef FCB_BAUD_ARB_WDOG_EN
        total++; if (tr_clr[11] !== 1'b1 || tr_busy[12] !== 1'b0) begin bad++; $display("FAIL wdog exit clear/busy got=%b/%b exp=1/0", tr_clr[11], tr_busy[12]); end
`endif
        total++; if (Busy_o !== 1'b0) begin bad++; $display("FAIL wdog final busy got=%b exp=0", Busy_o); end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        Req0_Divisor_i = 16'd5; Req0_Bits_i = 8'd3;
        Req1_Divisor_i = 16'd7; Req1_Bits_i = 8'd1;
        run_cycles(2'b11, 13, -1, 2'b00, 1'b0);
        total++; if (tr_gnt[13] !== 2'b01 || tr_cnt[13] !== 8'd1) begin bad++; $display("FAIL rstrun pre gnt/bitcnt got=%b/%0d exp=01/1", tr_gnt[13], tr_cnt[13]); end
        #2 RST_i = 1'b1;
        #1;
        total++; if (Divisor_o !== 16'h0001 || Bit_Cnt_o !== '0) begin bad++; $display("FAIL rstrun divisor/bitcnt got=%h/%0d exp=0001/0", Divisor_o, Bit_Cnt_o); end
        total++; if (Clear_Br_Cnt_o !== 1'b1 || Busy_o !== 1'b0) begin bad++; $display("FAIL rstrun clear/busy got=%b/%b exp=1/0", Clear_Br_Cnt_o, Busy_o); end
        total++; if (Gnt_o !== 2'b00 || Done_o !== 2'b00 || Err_o !== 2'b00) begin bad++; $display("FAIL rstrun gnt/done/err got=%b/%b/%b exp=00/00/00", Gnt_o, Done_o, Err_o); end
        @(negedge Bus_Clk_i);
        RST_i = 1'b0;
        run_cycles(2'b11, 3, -1, 2'b00, 1'b0);
        Req_i = 2'b00;
        @(negedge Bus_Clk_i);
        total++; if (tr_gnt[1] !== 2'b01) begin bad++; $display("FAIL rstrun pointer gnt got=%b exp=01", tr_gnt[1]); end
    endtask

    task automatic test_random();
        logic [1:0] req;
        logic [1:0] oh;
        int w, d, n, exp_done;
        do_reset();
        for (int t = 0; t < 12; t++) begin
            req            = 2'($urandom_range(1, 3));
            Req0_Divisor_i = 16'($urandom_range(0, 4));
            Req1_Divisor_i = 16'($urandom_range(0, 4));
            Req0_Bits_i    = NBW'($urandom_range(0, 5));
            Req1_Bits_i    = NBW'($urandom_range(0, 5));
            w = (req == 2'b01) ? 0 : (req == 2'b10) ? 1 : 1 - last_gnt;
            last_gnt = w;
            d  = (w == 1) ? int'(Req1_Divisor_i) : int'(Req0_Divisor_i);
            if (d == 0) d = 1;
            n  = (w == 1) ? int'(Req1_Bits_i) : int'(Req0_Bits_i);
            exp_done = (n == 0) ? 2 : 3 + 2 * d * n;
            oh = (w == 1) ? 2'b10 : 2'b01;
            run_cycles(req, exp_done + 1, -1, 2'b00, 1'b1);
            for (int c = 1; c <= exp_done + 1; c++) begin
                total++; if (tr_done[c] !== ((c == exp_done) ? oh : 2'b00)) begin bad++; $display("FAIL rnd%0d done c=%0d got=%b exp_at=%0d", t, c, tr_done[c], exp_done); end
                total++; if (tr_gnt[c] !== ((c <= exp_done) ? oh : 2'b00)) begin bad++; $display("FAIL rnd%0d gnt c=%0d got=%b exp=%b", t, c, tr_gnt[c], (c <= exp_done) ? oh : 2'b00); end
                total++; if (tr_clr[c] !== !(n != 0 && c >= 2 && c < exp_done)) begin bad++; $display("FAIL rnd%0d clear c=%0d got=%b", t, c, tr_clr[c]); end
                total++; if (tr_busy[c] !== (c <= exp_done)) begin bad++; $display("FAIL rnd%0d busy c=%0d got=%b", t, c, tr_busy[c]); end
                if (c <= exp_done) begin
                    total++; if (tr_div[c] !== 16'(d)) begin bad++; $display("FAIL rnd%0d divisor c=%0d got=%0d exp=%0d", t, c, tr_div[c], d); end
                end
            end
            total++; if (tr_cnt[exp_done] !== NBW'(n)) begin bad++; $display("FAIL rnd%0d bitcnt got=%0d exp=%0d", t, tr_cnt[exp_done], n); end
        end
        Req_i = 2'b00;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_zero();
        test_abort();
        test_abort_final();
        test_watchdog();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fcb_baud_arbiter.md
# fcb_baud_arbiter

Sequencing and arbitration controller for the FCB baud generator. It shares one baud generator between two serial requesters: it grants the generator round-robin, loads the winner's divisor, parks and releases the generator's counter clear, and counts a requested number of baud periods. It then returns a done pulse. It sits between the FCB serial engines and the baud generator instance.

## Interface
Parameters:
- NUM_BITS_W, 8, width of the per-request period count.

Ports:
- Bus_Clk_i  in  1  system clock; all state on rising edge.
- RST_i  in  1  reset, asynchronous, active-high.
- Req_i  in  2  per-requester request; level, held until Done_o/Err_o.
- Req0_Divisor_i / Req1_Divisor_i  in  16 each  half-period divisor D for each requester.
- Req0_Bits_i / Req1_Bits_i  in  NUM_BITS_W each  number of baud periods N.
- Baud_rate_fe_i  in  1  end-of-period strobe from the baud generator.
- Divisor_o  out  16  divisor driven to the baud generator.
- Clear_Br_Cnt_o  out  1  counter clear to the baud generator.
- Gnt_o  out  2  one-hot grant.
- Done_o  out  2  one-cycle completion pulse.
- Err_o  out  2  one-cycle watchdog error pulse; tied 0 without the macro.
- Busy_o  out  1  high in any state other than IDLE.
- Bit_Tick_o  out  1  Baud_rate_fe_i gated by RUN.
- Bit_Cnt_o  out  NUM_BITS_W  periods completed in the current grant.

## Operation
- States:
  - IDLE
  - LOAD
  - RUN
  - DONE
  - ERR (ERR exists only with the macro)
- IDLE: Clear_Br_Cnt_o=1, which parks the generator. If Req_i≠0, pick the winner and go to LOAD.
- Arbitration:
  - A single request wins outright.
  - When both request, the requester not granted last wins.
  - The last-grant pointer resets to 1, so req0 wins the first tie.
  - The pointer updates on entry to LOAD.
- LOAD:
  - Assert Gnt_o.
  - Latch the winner's D into Divisor_o; D=0 is substituted with 1.
  - Latch N.
  - Clear Bit_Cnt_o.
  - Clear_Br_Cnt_o=1.
  - Next state: RUN if N≠0, else DONE.
- RUN:
  - Clear_Br_Cnt_o=0.
  - Each Baud_rate_fe_i increments Bit_Cnt_o.
  - When the fe arrives with Bit_Cnt_o==N-1, go to DONE; Bit_Cnt_o ends at N.
- DONE: Done_o[gnt]=1 for one cycle, Clear_Br_Cnt_o=1, Gnt_o still held. Next state: IDLE.
- Abort:
  - If the granted Req_i bit drops during LOAD or RUN, go to IDLE next cycle.
  - No Done_o is issued; Clear_Br_Cnt_o reasserts.
  - If the drop coincides with the final fe, completion wins: DONE is entered and Done_o is pulsed.
- Requester rule: Req_i must drop in the cycle after Done_o/Err_o. If it is still high in IDLE, it re-arbitrates normally.
- Divisor_o and the latched N are stable for the whole grant. Input changes during a grant are ignored.
- Reset values:
  - State IDLE
  - Divisor_o=16'h0001
  - Clear_Br_Cnt_o=1
  - Gnt_o=0
  - Done_o=0
  - Err_o=0
  - Busy_o=0
  - Bit_Cnt_o=0
  - last-grant pointer=1
- Reset mid-grant aborts immediately to these values.

## Timing
- Request sampled high in cycle 0 → LOAD in cycle 1 → RUN from cycle 2.
- With the generator cleared in LOAD, the first fe arrives in cycle 2+2D; subsequent fe pulses arrive every 2D cycles.
- Done_o pulses in cycle 3+2D·N, or cycle 2 for N=0.
- Gnt_o is high from cycle 1 through the DONE cycle inclusive and drops in IDLE.
- Back-to-back grants: after DONE, the next LOAD is at the earliest 2 cycles later (IDLE, then LOAD).
- Bit_Tick_o is combinational from Baud_rate_fe_i and the RUN state.
- All other outputs are registered.

## Configuration
- FCB_BAUD_ARB_WDOG_EN defined:
  - An 18-bit watchdog clears on RUN entry and on each fe, and increments otherwise in RUN.
  - When it reaches {D,1'b0}+4 before an fe arrives, go to ERR.
  - ERR: Err_o[gnt]=1 for one cycle, Clear_Br_Cnt_o=1, no Done_o, then IDLE.
- FCB_BAUD_ARB_WDOG_EN undefined:
  - No watchdog logic and no ERR state; Err_o=2'b00.
  - RUN waits indefinitely for fe.

## Test plan
- Single requester: req0 with D=3, N=2 → Divisor_o=3; Clear_Br_Cnt_o low in cycles 2–14; Bit_Tick_o in cycles 8 and 14; Done_o=2'b01 in cycle 15; Bit_Cnt_o=2.
- Tie: Req_i=2'b11 from reset with D0=1, N0=1, D1=2, N1=1 →
  - Gnt_o=01 first, with Done_o[0] in cycle 5.
  - Then Gnt_o=10 and Divisor_o=2.
  - The next tie grants req0.
- N=0 and D=0: req1 with D=0, N=0 → Divisor_o=1, LOAD then DONE, Done_o=2'b10 in cycle 2, no RUN.
- Abort: req0 with D=4, N=3; drop Req_i[0] in cycle 5 → IDLE in cycle 6, Clear_Br_Cnt_o=1, Done_o never asserted. Dropping instead on the final fe cycle still yields Done_o.
- Watchdog (with macro): D=2 and Baud_rate_fe_i forced 0 → Err_o[gnt] in cycle 2+8+1, then IDLE. Without the macro, the block stays in RUN and Busy_o=1.
- Reset mid-RUN: assert RST_i asynchronously → all outputs at reset values in the same cycle, and the pointer returns to 1.
